// File: rtl/noc_egress_credit_buffer_if.sv
// Flit handshake between the node splitter, the egress buffer and the router local input.
// The master side presents flits and returns credits; the slave side buffers and forwards.
interface noc_egress_credit_buffer_if #(
    parameter int FLIT_W = 26
);
    logic [FLIT_W-1:0] node_flit_in;
    logic              node_accept;
    logic [FLIT_W-1:0] router_flit_out;
    logic              credit_in;

    modport master (
        output node_flit_in,
        output credit_in,
        input  node_accept,
        input  router_flit_out
    );

    modport slave (
        input  node_flit_in,
        input  credit_in,
        output node_accept,
        output router_flit_out
    );
endinterface

// File: rtl/noc_egress_credit_buffer.sv
// Egress FIFO between a node splitter and the router local port, released under
// credit-based flow control, with sticky drop and credit-protocol error flags.
module noc_egress_credit_buffer #(
    parameter int NODE_COUNT      = 9,
    parameter int PACKET_ID_WIDTH = 5,
    parameter int FIFO_DEPTH      = 8,
    parameter int CREDITS         = 4,
    localparam int FLIT_W = 1 + 2*$clog2(NODE_COUNT) + 8 + PACKET_ID_WIDTH + 4,
    localparam int CNT_W  = $clog2(FIFO_DEPTH+1),
    localparam int CRD_W  = $clog2(CREDITS+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    noc_egress_credit_buffer_if.slave bus,
    output logic [CNT_W-1:0]         fifo_count,
    output logic [CRD_W-1:0]         credit_count,
    output logic                     drop_err,
    output logic                     credit_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] depthMax  = CNT_W'(FIFO_DEPTH);
    localparam logic [CRD_W-1:0] creditMax = CRD_W'(CREDITS);

    logic [FLIT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;
    logic [CNT_W-1:0]  countNext;
    logic              flitValid;
    logic              isFull;
    logic              doWrite;
    logic              doSend;

    // Full and send decisions use registered state only, so a read in the
    // same cycle never frees a slot for the incoming flit.
    always_comb begin
        flitValid = bus.node_flit_in[FLIT_W-1];
        isFull    = (fifo_count == depthMax);
        doWrite   = flitValid && !isFull;
        doSend    = (fifo_count != '0) && (credit_count != '0);
        countNext = fifo_count;
        if (doWrite && !doSend) begin
            countNext = fifo_count + 1'b1;
        end else if (!doWrite && doSend) begin
            countNext = fifo_count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (doWrite) begin
            mem[wrPtr] <= bus.node_flit_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr               <= '0;
            rdPtr               <= '0;
            fifo_count          <= '0;
            credit_count        <= creditMax;
            bus.router_flit_out <= '0;
            bus.node_accept     <= 1'b1;
            drop_err            <= 1'b0;
            credit_err          <= 1'b0;
        end else begin
            if (doWrite) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doSend) begin
                rdPtr <= rdPtr + 1'b1;
            end
            fifo_count          <= countNext;
            bus.node_accept     <= (countNext != depthMax);
            bus.router_flit_out <= doSend ? mem[rdPtr] : '0;
            if (flitValid && isFull) begin
                drop_err <= 1'b1;
            end
            // A returned credit coinciding with a send nets to zero and is legal at the maximum.
            case ({doSend, bus.credit_in})
                2'b10: credit_count <= credit_count - 1'b1;
                2'b01: begin
                    if (credit_count == creditMax) begin
                        credit_err <= 1'b1;
                    end else begin
                        credit_count <= credit_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
